// File: rtl/multiport_register_file_pkg.sv
// Shared widths, types and constants for the multiport integer register file.
package regfile_pkg;
   localparam int XLEN_DEFAULT           = 32;
   localparam int REG_ADDR_WIDTH_DEFAULT = 5;

   typedef logic [REG_ADDR_WIDTH_DEFAULT-1:0] reg_addr_t;
   typedef logic [XLEN_DEFAULT-1:0]           xlen_t;

   localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/multiport_register_file_if.sv
// Bus bundle between decode/issue, writeback and the register file.
// master = pipeline side driving addresses/writes/issue, slave = register file.
interface multiport_register_file_if
   import regfile_pkg::*;
#(
   parameter int XLEN           = XLEN_DEFAULT,
   parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT,
   parameter int NUM_READ       = 2,
   parameter int NUM_WRITE      = 1
);
   logic [NUM_READ-1:0][REG_ADDR_WIDTH-1:0]  read_address_i;
   logic [NUM_READ-1:0][XLEN-1:0]            read_data_o;
   logic [NUM_READ-1:0]                      read_busy_o;
   logic [NUM_WRITE-1:0]                     write_enable_i;
   logic [NUM_WRITE-1:0][REG_ADDR_WIDTH-1:0] write_address_i;
   logic [NUM_WRITE-1:0][XLEN-1:0]           write_data_i;
   logic                                     issue_valid_i;
   logic [REG_ADDR_WIDTH-1:0]                issue_rd_i;
   logic [(2**REG_ADDR_WIDTH)-1:0]           busy_o;

   modport master (
      output read_address_i, write_enable_i, write_address_i, write_data_i,
             issue_valid_i, issue_rd_i,
      input  read_data_o, read_busy_o, busy_o
   );

   modport slave (
      input  read_address_i, write_enable_i, write_address_i, write_data_i,
             issue_valid_i, issue_rd_i,
      output read_data_o, read_busy_o, busy_o
   );
endinterface

// File: rtl/multiport_register_file_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, set beats clear.
// x0 has no flop; its busy bit is tied low.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT,
   parameter int NUM_WRITE      = 1,
   localparam int DEPTH         = 2**REG_ADDR_WIDTH
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,
   input  logic                                     issue_valid_i,
   input  logic [REG_ADDR_WIDTH-1:0]                issue_rd_i,
   input  logic [NUM_WRITE-1:0]                     write_enable_i,
   input  logic [NUM_WRITE-1:0][REG_ADDR_WIDTH-1:0] write_address_i,
   output logic [DEPTH-1:0]                         busy_o
);
   logic [DEPTH-1:1] busy_q;
   logic [DEPTH-1:1] set_vec;
   logic [DEPTH-1:1] clr_vec;

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      for (int r = 1; r < DEPTH; r++) begin
         if (issue_valid_i && (issue_rd_i == REG_ADDR_WIDTH'(r)))
            set_vec[r] = 1'b1;
         for (int k = 0; k < NUM_WRITE; k++) begin
            if (write_enable_i[k] && (write_address_i[k] == REG_ADDR_WIDTH'(r)))
               clr_vec[r] = 1'b1;
         end
      end
   end

   // A new producer issuing to r supersedes the one completing this cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         busy_q <= '0;
      else
         busy_q <= set_vec | (busy_q & ~clr_vec);
   end

   assign busy_o = {busy_q, 1'b0};
endmodule

// File: rtl/multiport_register_file.sv
// NUM_READ x NUM_WRITE integer register file with async reset and busy scoreboard.
// Optional REGFILE_WRITE_BYPASS_EN forwards same-cycle write data to read ports.
module multiport_register_file
   import regfile_pkg::*;
#(
   parameter int XLEN           = XLEN_DEFAULT,
   parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT,
   parameter int NUM_READ       = 2,
   parameter int NUM_WRITE      = 1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   multiport_register_file_if.slave  bus
);
   localparam int DEPTH = 2**REG_ADDR_WIDTH;
   localparam logic [REG_ADDR_WIDTH-1:0] ADDR_ZERO = REG_ADDR_WIDTH'(REG_ZERO);

   logic [XLEN-1:0] mem [DEPTH];

   // Later ports overwrite earlier ones, so the highest index wins a collision.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int r = 0; r < DEPTH; r++)
            mem[r] <= '0;
      end else begin
         for (int k = 0; k < NUM_WRITE; k++) begin
            if (bus.write_enable_i[k] && (bus.write_address_i[k] != ADDR_ZERO))
               mem[bus.write_address_i[k]] <= bus.write_data_i[k];
         end
      end
   end

   regfile_scoreboard #(
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
      .NUM_WRITE      (NUM_WRITE)
   ) u_scoreboard (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .issue_valid_i   (bus.issue_valid_i),
      .issue_rd_i      (bus.issue_rd_i),
      .write_enable_i  (bus.write_enable_i),
      .write_address_i (bus.write_address_i),
      .busy_o          (bus.busy_o)
   );

   // Outputs are gated by rst_ni so a forwarded write cannot leak out during reset.
   always_comb begin
      bus.read_data_o = '0;
      bus.read_busy_o = '0;
      for (int p = 0; p < NUM_READ; p++) begin
         if (rst_ni && (bus.read_address_i[p] != ADDR_ZERO)) begin
            bus.read_data_o[p] = mem[bus.read_address_i[p]];
            bus.read_busy_o[p] = bus.busy_o[bus.read_address_i[p]];
`ifdef REGFILE_WRITE_BYPASS_EN
            for (int k = 0; k < NUM_WRITE; k++) begin
               if (bus.write_enable_i[k] && (bus.write_address_i[k] == bus.read_address_i[p])) begin
                  bus.read_data_o[p] = bus.write_data_i[k];
                  bus.read_busy_o[p] = 1'b0;
               end
            end
`else
            // Stored values only; a write is visible the cycle after its edge.
`endif
         end
      end
   end
endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench for multiport_register_file with 4 read and 2 write ports.
// Expectations follow the build: REGFILE_WRITE_BYPASS_EN selects forwarded values.
module tb_multiport_register_file;
   import regfile_pkg::*;

   localparam int NR = 4;
   localparam int NW = 2;
`ifdef REGFILE_WRITE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic clk_i;
   logic rst_ni;
   int   vectors;
   int   miscompares;

   multiport_register_file_if #(
      .XLEN(32), .REG_ADDR_WIDTH(5), .NUM_READ(NR), .NUM_WRITE(NW)
   ) bus ();

   multiport_register_file #(
      .XLEN(32), .REG_ADDR_WIDTH(5), .NUM_READ(NR), .NUM_WRITE(NW)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic idle();
      bus.read_address_i  = '0;
      bus.write_enable_i  = '0;
      bus.write_address_i = '0;
      bus.write_data_i    = '0;
      bus.issue_valid_i   = 1'b0;
      bus.issue_rd_i      = '0;
   endtask

   task automatic drive_write(input int k, input logic [4:0] addr, input logic [31:0] data);
      bus.write_enable_i[k]  = 1'b1;
      bus.write_address_i[k] = addr;
      bus.write_data_i[k]    = data;
   endtask

   task automatic drive_issue(input logic [4:0] rd);
      bus.issue_valid_i = 1'b1;
      bus.issue_rd_i    = rd;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      idle();
      @(negedge clk_i);
      drive_write(0, 5'd5, 32'hDEADBEEF);
      bus.read_address_i[0] = 5'd5;
      #1;
      vectors++;
      if (bus.read_data_o[0] !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_read_data: got %h, required %h", bus.read_data_o[0], 32'h0);
      end
      vectors++;
      if (bus.busy_o !== 32'h0 || bus.read_busy_o !== 4'h0) begin
         miscompares++;
         $display("FAIL reset_busy: got busy_o %h read_busy %b, required 0", bus.busy_o, bus.read_busy_o);
      end
      rst_ni = 1'b1;
      tick();
      bus.write_enable_i = '0;
      #1;
      vectors++;
      if (bus.read_data_o[0] !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL first_write_x5: got %h, required %h", bus.read_data_o[0], 32'hDEADBEEF);
      end
      rst_ni = 1'b0;
      #1;
      vectors++;
      if (bus.read_data_o[0] !== 32'h0) begin
         miscompares++;
         $display("FAIL async_reset_x5: got %h, required %h", bus.read_data_o[0], 32'h0);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      idle();
   endtask

   task automatic test_x0();
      @(negedge clk_i);
      idle();
      drive_write(0, 5'd0, 32'h1234);
      drive_issue(5'd0);
      #1;
      vectors++;
      if (bus.read_data_o[0] !== 32'h0) begin
         miscompares++;
         $display("FAIL x0_same_cycle: got %h, required %h", bus.read_data_o[0], 32'h0);
      end
      tick();
      vectors++;
      if (bus.read_data_o[0] !== 32'h0 || bus.read_busy_o[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL x0_after_write: got data %h busy %b, required 0/0", bus.read_data_o[0], bus.read_busy_o[0]);
      end
      vectors++;
      if (bus.busy_o !== 32'h0) begin
         miscompares++;
         $display("FAIL x0_scoreboard: got %h, required %h", bus.busy_o, 32'h0);
      end
   endtask

   task automatic test_write_collision();
      @(negedge clk_i);
      idle();
      drive_write(0, 5'd7, 32'h11);
      drive_write(1, 5'd7, 32'h22);
      bus.read_address_i[0] = 5'd7;
      #1;
      vectors++;
      if (bus.read_data_o[0] !== (BYPASS ? 32'h22 : 32'h0)) begin
         miscompares++;
         $display("FAIL collision_same_cycle: got %h, required %h", bus.read_data_o[0], (BYPASS ? 32'h22 : 32'h0));
      end
      tick();
      @(negedge clk_i);
      idle();
      bus.read_address_i[0] = 5'd7;
      #1;
      vectors++;
      if (bus.read_data_o[0] !== 32'h22) begin
         miscompares++;
         $display("FAIL collision_winner: got %h, required %h", bus.read_data_o[0], 32'h22);
      end
   endtask

   task automatic test_scoreboard();
      @(negedge clk_i);
      idle();
      drive_issue(5'd3);
      tick();
      vectors++;
      if (bus.busy_o !== 32'h8) begin
         miscompares++;
         $display("FAIL sb_issue_x3: got %h, required %h", bus.busy_o, 32'h8);
      end
      @(negedge clk_i);
      idle();
      bus.read_address_i[0] = 5'd3;
      drive_issue(5'd3);
      drive_write(0, 5'd3, 32'h33);
      #1;
      vectors++;
      if (bus.read_busy_o[0] !== (BYPASS ? 1'b0 : 1'b1)) begin
         miscompares++;
         $display("FAIL sb_read_busy_x3: got %b, required %b", bus.read_busy_o[0], (BYPASS ? 1'b0 : 1'b1));
      end
      tick();
      vectors++;
      if (bus.busy_o !== 32'h8) begin
         miscompares++;
         $display("FAIL sb_set_beats_clear: got %h, required %h", bus.busy_o, 32'h8);
      end
      @(negedge clk_i);
      idle();
      drive_write(0, 5'd3, 32'h34);
      tick();
      vectors++;
      if (bus.busy_o !== 32'h0) begin
         miscompares++;
         $display("FAIL sb_clear_x3: got %h, required %h", bus.busy_o, 32'h0);
      end
      @(negedge clk_i);
      idle();
      drive_issue(5'd10);
      tick();
      vectors++;
      if (bus.busy_o !== 32'h400) begin
         miscompares++;
         $display("FAIL sb_issue_x10: got %h, required %h", bus.busy_o, 32'h400);
      end
      @(negedge clk_i);
      idle();
      drive_write(1, 5'd10, 32'hA);
      bus.read_address_i[1] = 5'd10;
      #1;
      vectors++;
      if (bus.read_busy_o[1] !== (BYPASS ? 1'b0 : 1'b1)) begin
         miscompares++;
         $display("FAIL sb_read_busy_x10: got %b, required %b", bus.read_busy_o[1], (BYPASS ? 1'b0 : 1'b1));
      end
      tick();
      vectors++;
      if (bus.busy_o !== 32'h0) begin
         miscompares++;
         $display("FAIL sb_clear_port1: got %h, required %h", bus.busy_o, 32'h0);
      end
   endtask

   task automatic test_bypass();
      @(negedge clk_i);
      idle();
      drive_issue(5'd9);
      @(negedge clk_i);
      idle();
      drive_write(0, 5'd9, 32'hA5A5A5A5);
      bus.read_address_i[0] = 5'd9;
      #1;
      vectors++;
      if (bus.read_data_o[0] !== (BYPASS ? 32'hA5A5A5A5 : 32'h0)) begin
         miscompares++;
         $display("FAIL bypass_data: got %h, required %h", bus.read_data_o[0], (BYPASS ? 32'hA5A5A5A5 : 32'h0));
      end
      vectors++;
      if (bus.read_busy_o[0] !== (BYPASS ? 1'b0 : 1'b1)) begin
         miscompares++;
         $display("FAIL bypass_busy: got %b, required %b", bus.read_busy_o[0], (BYPASS ? 1'b0 : 1'b1));
      end
      tick();
      vectors++;
      if (bus.read_data_o[0] !== 32'hA5A5A5A5 || bus.read_busy_o[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL bypass_next_cycle: got data %h busy %b, required %h/0", bus.read_data_o[0], bus.read_busy_o[0], 32'hA5A5A5A5);
      end
   endtask

   task automatic test_multi_read();
      logic [3:0][4:0]  addr_b;
      logic [3:0][31:0] exp_b;
      @(negedge clk_i);
      idle();
      drive_write(0, 5'd1, 32'd1);
      drive_write(1, 5'd2, 32'd2);
      @(negedge clk_i);
      idle();
      drive_write(0, 5'd3, 32'd3);
      drive_write(1, 5'd4, 32'd4);
      @(negedge clk_i);
      idle();
      for (int p = 0; p < NR; p++)
         bus.read_address_i[p] = 5'(p + 1);
      #1;
      for (int p = 0; p < NR; p++) begin
         vectors++;
         if (bus.read_data_o[p] !== 32'(p + 1)) begin
            miscompares++;
            $display("FAIL multi_read_port%0d: got %h, required %h", p, bus.read_data_o[p], 32'(p + 1));
         end
      end
      addr_b = {5'd7, 5'd2, 5'd0, 5'd4};
      exp_b  = {32'h22, 32'd2, 32'd0, 32'd4};
      bus.read_address_i = addr_b;
      #1;
      for (int p = 0; p < NR; p++) begin
         vectors++;
         if (bus.read_data_o[p] !== exp_b[p]) begin
            miscompares++;
            $display("FAIL multi_read_mixed_port%0d: got %h, required %h", p, bus.read_data_o[p], exp_b[p]);
         end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk_i);
      idle();
      drive_issue(5'd12);
      drive_write(0, 5'd13, 32'h55);
      tick();
      vectors++;
      if (bus.busy_o !== 32'h1000) begin
         miscompares++;
         $display("FAIL mid_busy_x12: got %h, required %h", bus.busy_o, 32'h1000);
      end
      @(negedge clk_i);
      idle();
      drive_write(0, 5'd14, 32'h77);
      bus.read_address_i[0] = 5'd13;
      #1;
      rst_ni = 1'b0;
      #1;
      vectors++;
      if (bus.busy_o !== 32'h0 || bus.read_data_o[0] !== 32'h0) begin
         miscompares++;
         $display("FAIL mid_reset_clear: got busy %h data %h, required 0/0", bus.busy_o, bus.read_data_o[0]);
      end
      tick();
      @(negedge clk_i);
      rst_ni = 1'b1;
      idle();
      bus.read_address_i[0] = 5'd14;
      bus.read_address_i[1] = 5'd13;
      #1;
      vectors++;
      if (bus.read_data_o[0] !== 32'h0 || bus.read_data_o[1] !== 32'h0) begin
         miscompares++;
         $display("FAIL mid_reset_discard: got x14 %h x13 %h, required 0/0", bus.read_data_o[0], bus.read_data_o[1]);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_ni      = 1'b0;
      idle();
      test_reset();
      test_x0();
      test_write_collision();
      test_scoreboard();
      test_bypass();
      test_multi_read();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
